// File: rtl/ultrasonic_pkg.sv
// rtl/ultrasonic_pkg.sv - shared types and default constants for the ultrasonic ranging blocks
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT_ECHO,
    S_MEASURE,
    S_DRAIN
  } meter_state_t;

  // 50 MHz clock: 58 us of round trip per centimetre, 1 ms echo start window
  localparam int CLKS_PER_CM = 2900;
  localparam int MAX_CM      = 400;
  localparam int WAIT_CYCLES = 50000;

  // Trigger generator: 100 ms measurement period, 10 us trigger pulse
  localparam int TRIG_PERIOD_CYCLES = 5_000_000;
  localparam int TRIG_PULSE_CYCLES  = 500;

endpackage

// File: rtl/echo_sync.sv
// rtl/echo_sync.sv - two-flop synchroniser for the asynchronous echo pin
module echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/echo_distance_meter.sv
// rtl/echo_distance_meter.sv - measures echo pulse width after each trigger, reports whole centimetres
module echo_distance_meter
  import ultrasonic_pkg::*;
#(
  parameter int CLKS_PER_CM = ultrasonic_pkg::CLKS_PER_CM,
  parameter int MAX_CM      = ultrasonic_pkg::MAX_CM,
  parameter int WAIT_CYCLES = ultrasonic_pkg::WAIT_CYCLES,
  parameter int DIST_W      = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigg,
  input  logic              echo,
  output logic [DIST_W-1:0] distance,
  output logic              valid,
  output logic              timeout,
  output logic              busy
);

  localparam int WAIT_W = $clog2(WAIT_CYCLES);
  localparam int PRE_W  = $clog2(CLKS_PER_CM);
  localparam int CM_W   = $clog2(MAX_CM + 1);

  meter_state_t state, state_n;

  logic              echo_s;
  logic              trigg_d;
  logic              trigg_rise;
  logic [WAIT_W-1:0] wait_cnt;
  logic [PRE_W-1:0]  presc;
  logic [CM_W-1:0]   cm_cnt;

  logic wait_clr, wait_inc, meas_start, meas_count, ld_dist, to_set;
  logic wait_done, pre_last, cm_full;

  echo_sync u_echo_sync (
    .clk   (clk),
    .reset (reset),
    .d     (echo),
    .q     (echo_s)
  );

  assign trigg_rise = trigg && !trigg_d;
  assign wait_done  = (wait_cnt == WAIT_W'(WAIT_CYCLES - 1));
  assign pre_last   = (presc == PRE_W'(CLKS_PER_CM - 1));
  assign cm_full    = (cm_cnt == CM_W'(MAX_CM));
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_n    = state;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    meas_start = 1'b0;
    meas_count = 1'b0;
    ld_dist    = 1'b0;
    to_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (trigg_rise) state_n = S_ARMED;
      end
      S_ARMED: begin
        if (!trigg) begin
          wait_clr = 1'b1;
          state_n  = S_WAIT_ECHO;
        end
      end
      S_WAIT_ECHO: begin
        wait_inc = 1'b1;
        if (echo_s) begin
          meas_start = 1'b1;
          state_n    = S_MEASURE;
        end else if (wait_done) begin
          to_set  = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_MEASURE: begin
        if (!echo_s) begin
          ld_dist = 1'b1;
          state_n = S_IDLE;
        end else begin
          meas_count = 1'b1;
          if (pre_last && cm_full) begin
            to_set  = 1'b1;
            state_n = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!echo_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      trigg_d  <= 1'b0;
      wait_cnt <= '0;
      presc    <= '0;
      cm_cnt   <= '0;
      distance <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state   <= state_n;
      trigg_d <= trigg;
      valid   <= ld_dist;
      timeout <= to_set;

      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      // The entry cycle already sees echo_s high, so it counts as the first cycle
      if (meas_start) begin
        presc  <= PRE_W'(1);
        cm_cnt <= '0;
      end else if (meas_count) begin
        if (pre_last) begin
          presc <= '0;
          if (!cm_full) cm_cnt <= cm_cnt + CM_W'(1);
        end else begin
          presc <= presc + PRE_W'(1);
        end
      end

      if (ld_dist) distance <= DIST_W'(cm_cnt);
    end
  end

endmodule

// File: tb/tb_echo_distance_meter.sv
// tb/tb_echo_distance_meter.sv - self-checking bench for echo_distance_meter
module tb_echo_distance_meter;

  localparam int C    = 10;
  localparam int MAXC = 20;
  localparam int W    = 100;
  localparam int DW   = 9;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          trigg = 1'b0;
  logic          echo  = 1'b0;
  logic [DW-1:0] distance;
  logic          valid;
  logic          timeout;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int both_cnt = 0;
  int last_dist = 0;
  logic prev_busy = 1'b0;

  int ev_kind[$];
  int ev_cyc[$];
  int ev_dist[$];
  int ev_busy[$];
  int fall_q[$];

  typedef struct {
    int d;
    int h;
    bit mid;
    bit exp_to;
    int exp_dist;
  } vec_t;

  vec_t vecs[$];

  echo_distance_meter #(
    .CLKS_PER_CM (C),
    .MAX_CM      (MAXC),
    .WAIT_CYCLES (W),
    .DIST_W      (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .trigg    (trigg),
    .echo     (echo),
    .distance (distance),
    .valid    (valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid || timeout) begin
      ev_kind.push_back(int'(timeout));
      ev_cyc.push_back(cyc);
      ev_dist.push_back(int'(distance));
      ev_busy.push_back(int'(busy));
    end
    if (valid && timeout) both_cnt <= both_cnt + 1;
    if (prev_busy && !busy) fall_q.push_back(cyc);
    prev_busy <= busy;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_events();
    ev_kind.delete();
    ev_cyc.delete();
    ev_dist.delete();
    ev_busy.delete();
    fall_q.delete();
  endtask

  // h < 0 means no echo at all; mid pulses trigg halfway through the echo
  task automatic run_meas(input int d, input int h, input bit mid, input bit exp_to, input int exp_dist);
    int  a1, r, f, exp_ev, exp_fall, budget;
    bit  done;
    clear_events();
    @(negedge clk); trigg = 1'b1;
    @(negedge clk); trigg = 1'b0; a1 = cyc + 1;
    check("busy_rise", int'(busy), 1);
    if (h < 0) begin
      exp_ev   = a1 + W;
      exp_fall = exp_ev;
      budget   = W + 20;
    end else begin
      repeat (d) @(negedge clk);
      echo = 1'b1;
      r = cyc;
      for (int i = 0; i < h; i++) begin
        trigg = mid && (i == h / 2);
        @(negedge clk);
      end
      trigg = 1'b0;
      echo  = 1'b0;
      f = cyc;
      exp_fall = f + 3;
      exp_ev   = exp_to ? r + 2 + (MAXC + 1) * C : f + 3;
      budget   = 20;
    end
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (ev_kind.size() > 0 && !busy) done = 1'b1;
    end
    check("complete_in_budget", int'(done), 1);
    repeat (4) @(negedge clk);
    check("event_count", ev_kind.size(), 1);
    if (ev_kind.size() > 0) begin
      check("event_kind_timeout", ev_kind[0], int'(exp_to));
      check("event_cycle", ev_cyc[0], exp_ev);
      check("event_distance", ev_dist[0], exp_dist);
      check("busy_at_event", ev_busy[0], (exp_to && h >= 0) ? 1 : 0);
    end
    check("busy_fall_count", fall_q.size(), 1);
    if (fall_q.size() > 0) check("busy_fall_cycle", fall_q[0], exp_fall);
    check("distance_held", int'(distance), exp_dist);
    last_dist = exp_dist;
  endtask

  initial begin
    int d, h, q;
    bit mid, over;

    vecs.push_back('{40, 100, 1'b0, 1'b0, 10});
    vecs.push_back('{5,    9, 1'b0, 1'b0,  0});
    vecs.push_back('{5,   10, 1'b0, 1'b0,  1});
    vecs.push_back('{0,  209, 1'b0, 1'b0, 20});
    vecs.push_back('{3,  210, 1'b0, 1'b1, 20});
    vecs.push_back('{0,   -1, 1'b0, 1'b1, 20});
    vecs.push_back('{20,  57, 1'b1, 1'b0,  5});
    vecs.push_back('{2,  199, 1'b1, 1'b0, 19});
    vecs.push_back('{7,  250, 1'b0, 1'b1, 19});

    repeat (3) @(negedge clk);
    check("reset_distance", int'(distance), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i])
      run_meas(vecs[i].d, vecs[i].h, vecs[i].mid, vecs[i].exp_to, vecs[i].exp_dist);

    // Reset in the middle of a measurement: no pulse, reset outputs, then recovers
    clear_events();
    @(negedge clk); trigg = 1'b1;
    @(negedge clk); trigg = 1'b0;
    repeat (2) @(negedge clk);
    echo = 1'b1;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midreset_distance", int'(distance), 0);
    check("midreset_valid", int'(valid), 0);
    check("midreset_timeout", int'(timeout), 0);
    check("midreset_busy", int'(busy), 0);
    echo = 1'b0;
    repeat (10) @(negedge clk);
    check("midreset_no_pulse", ev_kind.size(), 0);
    last_dist = 0;
    run_meas(5, 77, 1'b0, 1'b0, 7);

    for (int k = 0; k < 16; k++) begin
      d    = $urandom_range(0, 60);
      h    = $urandom_range(1, (MAXC + 2) * C);
      mid  = 1'($urandom_range(0, 1));
      q    = h / C;
      over = (q > MAXC);
      run_meas(d, h, mid, over, over ? last_dist : q);
    end

    check("valid_timeout_exclusive", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
